// File: rtl/systolic_result_drain.sv
// systolic_result_drain
// Write-back end of the systolic MAC array. Each BN_NUM-lane result vector is
// captured and then written out one element per write, in column-outer /
// row-block-inner order. Rows at or beyond OA_H (padding in the last row
// block) are never written.
//
// Ports:
//   clk        clock
//   reset_n    synchronous reset, active HIGH despite the name
//   start      one-cycle pulse, begins a full-matrix drain pass (IDLE only)
//   res_valid  result vector present on res_data
//   res_ready  block can accept a vector
//   res_data   lane n at bits [n*BW_ACT +: BW_ACT]
//   wr_valid   write request valid
//   wr_ready   memory accepts the write
//   wr_addr    row*OA_W + col
//   wr_data    element value
//   busy       high whenever not IDLE
//   done       one-cycle pulse after the final write of the pass is accepted
//
// Build option: define DRAIN_DOUBLE_BUF_EN to add a spare capture buffer so
// the next vector can be queued during DRAIN. This removes the WAIT bubble
// between vectors.
module systolic_result_drain #(
    parameter int BN_NUM = 8,
    parameter int BW_ACT = 8,
    parameter int OA_H   = 100,
    parameter int OA_W   = 16,
    parameter int ADDR_W = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     res_valid,
    output logic                     res_ready,
    input  logic [BN_NUM*BW_ACT-1:0] res_data,
    output logic                     wr_valid,
    input  logic                     wr_ready,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [BW_ACT-1:0]        wr_data,
    output logic                     busy,
    output logic                     done
);

    localparam int NBLK   = (OA_H + BN_NUM - 1) / BN_NUM;
    localparam int LANE_W = (BN_NUM > 1) ? $clog2(BN_NUM) : 1;
    localparam int BLK_W  = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam int COL_W  = (OA_W > 1) ? $clog2(OA_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t                          state;
    state_t                          state_nxt;
    logic [LANE_W-1:0]               lane;
    logic [BLK_W-1:0]                blk;
    logic [COL_W-1:0]                col;
    logic [BN_NUM-1:0][BW_ACT-1:0]   cur_buf;
    logic [ADDR_W-1:0]               row;
    logic                            vec_end;
    logic                            last_blk;
    logic                            last_col;
`ifdef DRAIN_DOUBLE_BUF_EN
    logic [BN_NUM-1:0][BW_ACT-1:0]   spare_buf;
    logic                            spare_full;
`endif

    assign row      = ADDR_W'(blk) * ADDR_W'(BN_NUM) + ADDR_W'(lane);
    // Comparing against OA_H-1 avoids the row+1 overflow when OA_H fills
    // the whole address space.
    assign vec_end  = (lane == LANE_W'(BN_NUM - 1)) || (row >= ADDR_W'(OA_H - 1));
    assign last_blk = (blk == BLK_W'(NBLK - 1));
    assign last_col = (col == COL_W'(OA_W - 1));

    always_comb begin
        state_nxt = state;
        res_ready = 1'b0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        busy      = (state != S_IDLE);
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                res_ready = 1'b1;
                if (res_valid) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                wr_valid = 1'b1;
                wr_addr  = row * ADDR_W'(OA_W) + ADDR_W'(col);
                wr_data  = cur_buf[lane];
`ifdef DRAIN_DOUBLE_BUF_EN
                // Refuse vectors once the vector being drained is the
                // pass's last, so nothing beyond the pass is swallowed.
                res_ready = !spare_full && !(last_blk && last_col);
`endif
                if (wr_ready && vec_end) begin
                    if (last_blk && last_col) begin
                        state_nxt = S_FIN;
                    end else begin
`ifdef DRAIN_DOUBLE_BUF_EN
                        if (spare_full || (res_valid && res_ready))
                            state_nxt = S_DRAIN;
                        else
                            state_nxt = S_WAIT;
`else
                        state_nxt = S_WAIT;
`endif
                    end
                end
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state      <= S_IDLE;
            lane       <= '0;
            blk        <= '0;
            col        <= '0;
            cur_buf    <= '0;
`ifdef DRAIN_DOUBLE_BUF_EN
            spare_buf  <= '0;
            spare_full <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        lane <= '0;
                        blk  <= '0;
                        col  <= '0;
                    end
                end
                S_WAIT: begin
                    if (res_valid) begin
                        cur_buf <= res_data;
                        lane    <= '0;
                    end
                end
                S_DRAIN: begin
                    if (wr_ready) begin
                        if (vec_end) begin
                            lane <= '0;
                            if (last_blk) begin
                                blk <= '0;
                                if (!last_col) col <= col + 1'b1;
                            end else begin
                                blk <= blk + 1'b1;
                            end
`ifdef DRAIN_DOUBLE_BUF_EN
                            // Next vector comes from the spare, or straight
                            // from the input if it arrives on this very cycle.
                            if (spare_full) begin
                                cur_buf    <= spare_buf;
                                spare_full <= 1'b0;
                            end else if (res_valid && res_ready) begin
                                cur_buf <= res_data;
                            end
`endif
                        end else begin
                            lane <= lane + 1'b1;
                        end
                    end
`ifdef DRAIN_DOUBLE_BUF_EN
                    if (res_valid && res_ready && !(wr_ready && vec_end)) begin
                        spare_buf  <= res_data;
                        spare_full <= 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
